// File: rtl/stream_merge_2_to_1_pkg.sv
// Result-path package: source codes and arbiter state type for the 2:1 stream merge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_merge_2_to_1_pkg;

    // Source tag carried with every merged beat
    localparam logic FULLY_CONVOL = 1'b0;
    localparam logic MAX_POOLING  = 1'b1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_CONV = 2'd1,
        GRANT_POOL = 2'd2
    } state_e;

endpackage

// File: rtl/stream_merge_2_to_1_stream_out_reg.sv
// Single-entry registered output slice carrying data, source tag and last flag.
// Latency: a loaded beat is visible on out_* the cycle after load.
// Backpressure: accepts a new beat when empty or when the held beat leaves this cycle; holds stable while out_ready is low.
module stream_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  logic                  in_src,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic                  out_last
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  src_q, src_d;
    logic                  last_q, last_d;
    logic                  load;

    // Slot is free when empty or when its current beat drains this cycle
    assign in_rdy = !valid_q || out_ready;
    assign load   = in_vld && in_rdy;

    // Next-state of the slot: load a new beat, drain the old one, or hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_dat;
            src_d   = in_src;
            last_d  = in_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; reset discards any pending beat
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_last  = last_q;

endmodule

// File: rtl/stream_merge_2_to_1.sv
// Merges convolution and max-pooling result streams into one tagged writeback stream.
// Latency: one idle cycle per grant, then accepted beats appear on out_* one cycle later.
// Backpressure: granted source's ready follows the output slot (!out_valid || out_ready); other source held off.
module stream_merge_2_to_1
    import stream_merge_2_to_1_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  conv_valid,
    output logic                  conv_ready,
    input  logic [DATA_WIDTH-1:0] conv_data,
    input  logic                  conv_last,
    input  logic                  pool_valid,
    output logic                  pool_ready,
    input  logic [DATA_WIDTH-1:0] pool_data,
    input  logic                  pool_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic                  out_last,
    output logic                  busy
);

    localparam int               CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;

    logic                    slot_rdy;
    logic                    sel_vld;
    logic                    sel_rdy;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic                    sel_last;
    logic                    sel_src;
    logic                    accept;
    logic                    beat_last;

    // Route the granted source to the output slot; non-granted source sees ready low
    always_comb begin
        sel_vld    = 1'b0;
        sel_rdy    = 1'b0;
        sel_dat    = '0;
        sel_last   = 1'b0;
        sel_src    = FULLY_CONVOL;
        conv_ready = 1'b0;
        pool_ready = 1'b0;
        case (state_q)
            GRANT_CONV: begin
                conv_ready = slot_rdy;
                sel_rdy    = slot_rdy;
                sel_vld    = conv_valid;
                sel_dat    = conv_data;
                sel_last   = conv_last;
                sel_src    = FULLY_CONVOL;
            end
            GRANT_POOL: begin
                pool_ready = slot_rdy;
                sel_rdy    = slot_rdy;
                sel_vld    = pool_valid;
                sel_dat    = pool_data;
                sel_last   = pool_last;
                sel_src    = MAX_POOLING;
            end
            default: begin
            end
        endcase
        accept    = sel_vld && sel_rdy;
        // Grant ends on packet end or burst limit; coinciding is still a single end
        beat_last = sel_last || (beat_cnt_q == CNT_MAX);
    end

    // Arbiter: pick a source in IDLE (alternate on tie), release it at grant end
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (conv_valid && pool_valid) begin
                    state_d = (last_grant_q == MAX_POOLING) ? GRANT_CONV : GRANT_POOL;
                end else if (conv_valid) begin
                    state_d = GRANT_CONV;
                end else if (pool_valid) begin
                    state_d = GRANT_POOL;
                end
            end
            GRANT_CONV, GRANT_POOL: begin
                if (accept) begin
                    if (beat_last) begin
                        beat_cnt_d   = '0;
                        last_grant_d = sel_src;
                        state_d      = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter registers; pooling counts as last served so conv wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= MAX_POOLING;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (accept),
        .in_rdy    (slot_rdy),
        .in_dat    (sel_dat),
        .in_src    (sel_src),
        .in_last   (beat_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last)
    );

    assign busy = (state_q != IDLE) || out_valid;

endmodule
